register_vectorial_lanes: RTL

Parametrised successor to the 16 x 192-bit vector register file. It has three asynchronous read ports and one write port, and the write port is lane-masked so a single vector op can update a subset of lanes. Reads bypass same-cycle writes. A built-in clear sequencer zeroes the whole array after reset or on request, so every register starts from a known state. The block sits between the vector decode stage (RS1/RS2/RS3/RD) and the vector ALU/writeback.

---
 rtl/register_vectorial_lanes.sv | 67 ++++++
 1 files changed

// File: rtl/register_vectorial_lanes.sv
// register_vectorial_lanes: lane-masked 3R/1W vector register file with write bypass and clear sweep
module register_vectorial_lanes #(
  parameter int NUM_REGS = 16,
  parameter int LANES = 24,
  parameter int LANE_W = 8,
  localparam int AW = $clog2(NUM_REGS),
  localparam int VW = LANES * LANE_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] RS1,
  input  logic [AW-1:0] RS2,
  input  logic [AW-1:0] RS3,
  input  logic [AW-1:0] RD,
  input  logic [VW-1:0] WD,
  input  logic [LANES-1:0] wr_mask,
  input  logic          wr_enable,
  input  logic          clr_req,
  output logic [VW-1:0] RD1,
  output logic [VW-1:0] RD2,
  output logic [VW-1:0] RD3,
  output logic          busy,
  output logic          wr_dropped
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state;
  logic [AW:0] idx;
  logic [VW-1:0] regs [NUM_REGS];
  logic [VW-1:0] lane_bits;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_bits[k*LANE_W +: LANE_W] = {LANE_W{wr_mask[k]}};
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= CLEAR;
      idx <= '0;
      busy <= 1'b1;
      wr_dropped <= 1'b0;
    end else begin
      wr_dropped <= wr_enable && busy;
      if (state == CLEAR) begin
        idx <= idx + 1'b1;
        if (idx == (AW+1)'(NUM_REGS - 1)) begin
          state <= IDLE;
          busy <= 1'b0;
        end
      end else if (clr_req) begin
        state <= CLEAR;
        idx <= '0;
        busy <= 1'b1;
      end
    end
  end
  // Array has no reset; a write coinciding with clr_req still lands and is swept later
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == CLEAR) regs[idx[AW-1:0]] <= '0;
      else if (wr_enable) regs[RD] <= (WD & lane_bits) | (regs[RD] & ~lane_bits);
    end
  end
  function automatic logic [VW-1:0] rd_port(input logic [AW-1:0] a);
    return busy ? '0 : (wr_enable && a == RD) ? (WD & lane_bits) | (regs[a] & ~lane_bits) : regs[a];
  endfunction
  always_comb RD1 = rd_port(RS1);
  always_comb RD2 = rd_port(RS2);
  always_comb RD3 = rd_port(RS3);
endmodule
